alu: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_shifter.sv | 24 ++
 rtl/alu.sv | 57 +++++
 tb/tb_alu.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and widths for the RV32I integer ALU.
package alu_pkg;
  localparam int XLEN = 32;
  localparam int SHAMT_W = 5;
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_func3_e;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: 32-bit log barrel shifter for SLL, SRL and SRA.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    data_i,
  input  logic               dir_i,
  input  logic               arith_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [XLEN-1:0]    data_o
);
  logic [XLEN-1:0] rev_in;
  logic [XLEN-1:0] st [SHAMT_W+1];
  logic fill;
  // Left shifts reuse the right-shift stages by bit-reversing input and output.
  assign fill = arith_i & ~dir_i & data_i[XLEN-1];
  assign st[0] = dir_i ? rev_in : data_i;
  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign rev_in[i] = data_i[XLEN-1-i];
    assign data_o[i] = dir_i ? st[SHAMT_W][XLEN-1-i] : st[SHAMT_W][i];
  end
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_st
    assign st[s+1] = shamt_i[s] ? {{(1 << s){fill}}, st[s][XLEN-1:(1 << s)]} : st[s];
  end
endmodule

// File: rtl/alu.sv
// alu: RV32I integer ALU with combinational result and a registered copy plus zero flag.
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [2:0]      func3,
  input  logic            subsra,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q
);
  import alu_pkg::*;
  alu_func3_e f3;
  logic sub, ovf, slt, sltu, zero_d;
  logic [XLEN:0] sum;
  logic [XLEN-1:0] sh, result_d;
  assign f3 = alu_func3_e'(func3);
  // Compares always subtract; only the ADD code lets subsra choose.
  assign sub = (f3 == F3_ADD) ? subsra : 1'b1;
  assign sum = {1'b0, operand1} + {1'b0, operand2 ^ {XLEN{sub}}} + {{XLEN{1'b0}}, sub};
  assign ovf = (operand1[XLEN-1] ^ operand2[XLEN-1]) & (sum[XLEN-1] ^ operand1[XLEN-1]);
  assign slt = sum[XLEN-1] ^ ovf;
  assign sltu = ~sum[XLEN];
  alu_shifter u_shifter (
    .data_i (operand1),
    .dir_i  (f3 == F3_SLL),
    .arith_i(subsra),
    .shamt_i(operand2[SHAMT_W-1:0]),
    .data_o (sh)
  );
  always_comb begin
    case (f3)
      F3_ADD:        result = sum[XLEN-1:0];
      F3_SLL, F3_SR: result = sh;
      F3_SLT:        result = {{(XLEN-1){1'b0}}, slt};
      F3_SLTU:       result = {{(XLEN-1){1'b0}}, sltu};
      F3_XOR:        result = operand1 ^ operand2;
      F3_OR:         result = operand1 | operand2;
      F3_AND:        result = operand1 & operand2;
      default:       result = '0;
    endcase
  end
  assign result_d = result;
  assign zero_d = (result == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against a behavioural model.
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] operand1 = '0, operand2 = '0;
  logic [2:0] func3 = '0;
  logic subsra = 1'b0;
  logic [31:0] result, result_q;
  logic zero_q;
  logic [31:0] exp_q;
  logic exp_z;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .operand1(operand1), .operand2(operand2),
    .func3(func3), .subsra(subsra), .result(result), .result_q(result_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [2:0] f, logic s, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sra;
    sa = a;
    sra = sa >>> b[4:0];
    case (f)
      3'd0: return s ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return s ? sra : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (f3=%0d s=%0b a=%h b=%h)", name, act, exp, func3, subsra, operand1, operand2);
    end
  endtask

  always @(posedge clk) begin
    exp_q <= rst ? 32'h0 : ref_alu(func3, subsra, operand1, operand2);
    exp_z <= rst ? 1'b1 : (ref_alu(func3, subsra, operand1, operand2) == 32'h0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("result", result, ref_alu(func3, subsra, operand1, operand2));
      check("result_q", result_q, exp_q);
      check("zero_q", {31'h0, zero_q}, {31'h0, exp_z});
    end
  end

  task automatic drive(logic r, logic [2:0] f, logic s, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #2;
    rst = r; func3 = f; subsra = s; operand1 = a; operand2 = b;
  endtask

  task automatic dt(string name, logic [2:0] f, logic s, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    drive(1'b0, f, s, a, b);
    #1;
    check(name, result, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_result_q", result_q, 32'h0);
    check("rst_zero_q", {31'h0, zero_q}, 32'h1);
    chk_en = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 32'h10, 32'h5);
    @(posedge clk); #1;
    check("reg_add_q", result_q, 32'h15);
    check("reg_add_z", {31'h0, zero_q}, 32'h0);
    #1;
    func3 = 3'd0; subsra = 1'b1; operand1 = 32'h7; operand2 = 32'h7;
    @(posedge clk); #1;
    check("reg_sub_q", result_q, 32'h0);
    check("reg_sub_z", {31'h0, zero_q}, 32'h1);
    #1;
    rst = 1'b1; func3 = 3'd0; subsra = 1'b0; operand1 = 32'h10; operand2 = 32'h5;
    @(posedge clk); #1;
    check("reg_rst_q", result_q, 32'h0);
    check("reg_rst_z", {31'h0, zero_q}, 32'h1);
    dt("add", 3'd0, 1'b0, 32'h10, 32'h5, 32'h15);
    dt("sub", 3'd0, 1'b1, 32'h10, 32'h5, 32'h0B);
    dt("sub_wrap", 3'd0, 1'b1, 32'h0, 32'h1, 32'hFFFFFFFF);
    dt("slt_neg", 3'd2, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h1);
    dt("slt_pos", 3'd2, 1'b0, 32'h5, 32'h3, 32'h0);
    dt("sltu_big", 3'd3, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0);
    dt("sltu_small", 3'd3, 1'b0, 32'h2, 32'h5, 32'h1);
    dt("sll", 3'd1, 1'b0, 32'h1, 32'h4, 32'h10);
    dt("sll_5bit", 3'd1, 1'b0, 32'h1, 32'h25, 32'h20);
    dt("srl", 3'd5, 1'b0, 32'h80000000, 32'h4, 32'h08000000);
    dt("sra", 3'd5, 1'b1, 32'h80000000, 32'h4, 32'hF8000000);
    dt("xor", 3'd4, 1'b0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0);
    dt("or", 3'd6, 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF);
    dt("and", 3'd7, 1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F);
    dt("xor_s1", 3'd4, 1'b1, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0);
    dt("or_s1", 3'd6, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF);
    dt("and_s1", 3'd7, 1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h0F0F0F0F);
    dt("slt_s1", 3'd2, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h1);
    dt("sltu_s1", 3'd3, 1'b1, 32'h2, 32'h5, 32'h1);
    dt("slt_ovf", 3'd2, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h1);
    dt("sltu_eq", 3'd3, 1'b0, 32'h1234, 32'h1234, 32'h0);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 9) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a = {$urandom_range(0, 1) == 1, 31'h0};
      drive($urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
